// File: rtl/myo_spi_scheduler.sv
// Round-robin frame scheduler for the shared myocontrol SPI bus, with one-shot host frames.
// Define MYO_SCHED_TIMEOUT_EN to enable the spi_done watchdog and the sticky timeout_err flag.
module myo_spi_scheduler #(
  parameter int NUM_SLAVES     = 7,
  parameter int SEL_W          = 3,
  parameter int SETUP_CYCLES   = 4,
  parameter int GAP_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_SLAVES-1:0] slave_mask,
  input  logic                  host_req,
  input  logic [SEL_W-1:0]      host_slave,
  output logic                  host_grant,
  output logic                  host_done,
  output logic                  spi_start,
  input  logic                  spi_done,
  output logic [SEL_W-1:0]      spi_slave,
  output logic [NUM_SLAVES-1:0] ss_n,
  output logic                  frame_active,
  output logic                  round_done,
  output logic                  timeout_err
);

  localparam int MAX_SG  = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SEL_W:0] NUM_SEL = (SEL_W + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_GAP} state_t;

  state_t                  state_r, state_n;
  logic [CNT_W-1:0]        cnt_r, cnt_n;
  logic [SEL_W-1:0]        sel_r, rr_ptr_r;
  logic                    frame_host_r, frame_last_r, host_busy_r;
  logic                    host_grant_r, host_done_r, spi_start_r, round_done_r, frame_active_r;
  logic [NUM_SLAVES-1:0]   ss_n_r;

  logic                    host_ok_s, host_valid_s, launch_host_s, drop_host_s, launch_rr_s, launch_s;
  logic                    rr_found_s, sel_point_s, frame_end_s, active_n_s;
  logic [SEL_W-1:0]        rr_idx_s, hi_idx_s, sel_idx_s, sel_n_s;

  function automatic logic [NUM_SLAVES-1:0] sel_to_ss_n(input logic [SEL_W-1:0] sel);
    logic [NUM_SLAVES-1:0] v;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      v[i] = (sel != SEL_W'(i));
    end
    return v;
  endfunction

  // Candidate selection: pending host frame first, else next masked slave after rr_ptr.
  always_comb begin
    host_ok_s    = host_req && !host_busy_r && !host_done_r;
    host_valid_s = ({1'b0, host_slave} < NUM_SEL);
    rr_found_s   = 1'b0;
    rr_idx_s     = '0;
    hi_idx_s     = '0;
    for (int i = 1; i <= NUM_SLAVES; i++) begin
      logic [SEL_W-1:0] idx_v;
      idx_v      = SEL_W'((int'(rr_ptr_r) + i) % NUM_SLAVES);
      rr_idx_s   = (!rr_found_s && slave_mask[idx_v]) ? idx_v : rr_idx_s;
      rr_found_s = rr_found_s | slave_mask[idx_v];
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hi_idx_s = slave_mask[i] ? SEL_W'(i) : hi_idx_s;
    end
    launch_host_s = host_ok_s && host_valid_s;
    drop_host_s   = host_ok_s && !host_valid_s;
    launch_rr_s   = !host_ok_s && enable && rr_found_s;
    launch_s      = launch_host_s || launch_rr_s;
    sel_idx_s     = launch_host_s ? host_slave : rr_idx_s;
  end

  assign sel_point_s = (state_r == ST_IDLE) ||
                       ((state_r == ST_GAP) && (cnt_r == CNT_W'(GAP_CYCLES - 1)));

`ifdef MYO_SCHED_TIMEOUT_EN
  logic timeout_s;
  logic timeout_err_r;
  assign timeout_s = (state_r == ST_XFER) && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                     !(spi_done && (cnt_r != '0));
`endif

  // Next-state logic; in XFER the counter marks the first cycle (and measures the watchdog).
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    frame_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_n = launch_s ? ST_SETUP : ST_IDLE;
        cnt_n   = '0;
      end
      ST_SETUP: begin
        if (cnt_r == CNT_W'(SETUP_CYCLES - 1)) begin
          state_n = ST_XFER;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      ST_XFER: begin
`ifdef MYO_SCHED_TIMEOUT_EN
        frame_end_s = (spi_done && (cnt_r != '0)) || timeout_s;
        cnt_n       = cnt_r + CNT_W'(1);
`else
        frame_end_s = spi_done && (cnt_r != '0);
        cnt_n       = CNT_W'(1);
`endif
        if (frame_end_s) begin
          state_n = ST_GAP;
          cnt_n   = '0;
        end else begin
          state_n = ST_XFER;
        end
      end
      ST_GAP: begin
        if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
          state_n = launch_s ? ST_SETUP : ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    sel_n_s    = (sel_point_s && launch_s) ? sel_idx_s : sel_r;
    active_n_s = (state_n == ST_SETUP) || (state_n == ST_XFER);
  end

  // State, frame bookkeeping and registered bus/handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      sel_r          <= '0;
      rr_ptr_r       <= SEL_W'(NUM_SLAVES - 1);
      frame_host_r   <= 1'b0;
      frame_last_r   <= 1'b0;
      host_busy_r    <= 1'b0;
      host_grant_r   <= 1'b0;
      host_done_r    <= 1'b0;
      spi_start_r    <= 1'b0;
      round_done_r   <= 1'b0;
      frame_active_r <= 1'b0;
      ss_n_r         <= {NUM_SLAVES{1'b1}};
    end else begin
      state_r        <= state_n;
      cnt_r          <= cnt_n;
      sel_r          <= sel_n_s;
      ss_n_r         <= active_n_s ? sel_to_ss_n(sel_n_s) : {NUM_SLAVES{1'b1}};
      frame_active_r <= active_n_s;
      spi_start_r    <= (state_r == ST_SETUP) && (state_n == ST_XFER);
      host_grant_r   <= sel_point_s && host_ok_s;
      host_done_r    <= (sel_point_s && drop_host_s) || (frame_end_s && frame_host_r);
      round_done_r   <= frame_end_s && !frame_host_r && frame_last_r;
      if (sel_point_s && launch_s) begin
        frame_host_r <= launch_host_s;
        frame_last_r <= launch_rr_s && (rr_idx_s == hi_idx_s);
      end
      if (sel_point_s && launch_rr_s) begin
        rr_ptr_r <= rr_idx_s;
      end
      // host_done_r also blocks re-grant for the cycle the host needs to drop host_req.
      if (sel_point_s && launch_host_s) begin
        host_busy_r <= 1'b1;
      end else if (frame_end_s && frame_host_r) begin
        host_busy_r <= 1'b0;
      end
    end
  end

`ifdef MYO_SCHED_TIMEOUT_EN
  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_s) begin
      timeout_err_r <= 1'b1;
    end
  end
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

  assign host_grant   = host_grant_r;
  assign host_done    = host_done_r;
  assign spi_start    = spi_start_r;
  assign spi_slave    = sel_r;
  assign ss_n         = ss_n_r;
  assign frame_active = frame_active_r;
  assign round_done   = round_done_r;

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Self-checking bench for myo_spi_scheduler: scripted scenarios plus randomized masks,
// host insertions and spi_done delays, checked against a frame-level reference model.
module tb_myo_spi_scheduler;

  localparam int NS    = 7;
  localparam int SW    = 3;
  localparam int SETUP = 4;
  localparam int GAP   = 50;
  localparam int TMO   = 16;
  localparam logic [NS-1:0] ALL1 = {NS{1'b1}};

  logic          clock = 1'b0;
  logic          reset, enable, host_req, spi_done;
  logic [NS-1:0] slave_mask;
  logic [SW-1:0] host_slave;
  logic          host_grant, host_done, spi_start, frame_active, round_done, timeout_err;
  logic [SW-1:0] spi_slave;
  logic [NS-1:0] ss_n;

  int checks = 0;
  int errors = 0;
  int model_ptr = NS - 1;

  myo_spi_scheduler #(
    .NUM_SLAVES(NS), .SEL_W(SW), .SETUP_CYCLES(SETUP), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .slave_mask(slave_mask),
    .host_req(host_req), .host_slave(host_slave), .host_grant(host_grant),
    .host_done(host_done), .spi_start(spi_start), .spi_done(spi_done),
    .spi_slave(spi_slave), .ss_n(ss_n), .frame_active(frame_active),
    .round_done(round_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Reference: next polled slave is the first set mask bit after the pointer, wrapping.
  function automatic int next_rr(input int ptr, input logic [NS-1:0] m);
    for (int k = 1; k <= NS; k++) begin
      if (m[(ptr + k) % NS]) return (ptr + k) % NS;
    end
    return -1;
  endfunction

  function automatic int top_bit(input logic [NS-1:0] m);
    int h;
    h = -1;
    for (int i = 0; i < NS; i++) if (m[i]) h = i;
    return h;
  endfunction

  function automatic logic [NS-1:0] ss_for(input int s);
    logic [NS-1:0] v;
    v = ALL1;
    v[s] = 1'b0;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_frame(input int exp_slave, input bit exp_host, input bit exp_last,
                          input int delay, input int inject, input bit drop_en, output int waited);
    int n;
    waited = 0;
    do begin step(); waited++; end while (ss_n === ALL1 && waited < 400);
    checks++;
    if (ss_n !== ss_for(exp_slave)) begin
      $display("FAIL frame_select: ss_n=%b expected %b", ss_n, ss_for(exp_slave));
      errors++;
    end
    if (ss_n === ALL1) return;
    checks++;
    if (spi_slave !== SW'(exp_slave)) begin
      $display("FAIL spi_slave: got %0d expected %0d", spi_slave, exp_slave);
      errors++;
    end
    checks++;
    if (host_grant !== exp_host) begin
      $display("FAIL host_grant: got %b expected %b", host_grant, exp_host);
      errors++;
    end
    n = 0;
    do begin step(); n++; end while (spi_start !== 1'b1 && n < 20);
    checks++;
    if (n != SETUP) begin
      $display("FAIL setup_len: got %0d cycles expected %0d", n, SETUP);
      errors++;
    end
    if (spi_start !== 1'b1) return;
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    checks++;
    if (frame_active !== 1'b1 || ss_n !== ss_for(exp_slave)) begin
      $display("FAIL first_xfer_done_ignored: active=%b ss_n=%b expected 1 %b",
               frame_active, ss_n, ss_for(exp_slave));
      errors++;
    end
    if (inject >= 0) begin
      host_req   = 1'b1;
      host_slave = SW'(inject);
    end
    if (drop_en) enable = 1'b0;
    repeat (delay - 1) step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    checks++;
    if (ss_n !== ALL1 || frame_active !== 1'b0) begin
      $display("FAIL frame_end: ss_n=%b active=%b expected %b 0", ss_n, frame_active, ALL1);
      errors++;
    end
    checks++;
    if (host_done !== exp_host) begin
      $display("FAIL host_done: got %b expected %b", host_done, exp_host);
      errors++;
    end
    checks++;
    if (round_done !== exp_last) begin
      $display("FAIL round_done: got %b expected %b", round_done, exp_last);
      errors++;
    end
    if (exp_host) host_req = 1'b0;
  endtask

  task automatic rr_frame(input int delay, input int inject, input bit drop_en, input int exp_wait);
    int s, w;
    s = next_rr(model_ptr, slave_mask);
    model_ptr = s;
    do_frame(s, 1'b0, s == top_bit(slave_mask), delay, inject, drop_en, w);
    if (exp_wait >= 0) begin
      checks++;
      if (w != exp_wait) begin
        $display("FAIL rr_wait: got %0d cycles expected %0d", w, exp_wait);
        errors++;
      end
    end
  endtask

  task automatic host_frame(input int slave, input int delay);
    int w;
    do_frame(slave, 1'b1, 1'b0, delay, -1, 1'b0, w);
    checks++;
    if (w != GAP) begin
      $display("FAIL host_gap: got %0d cycles expected %0d", w, GAP);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; host_req = 1'b0; spi_done = 1'b0;
    slave_mask = '0; host_slave = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (ss_n !== ALL1 || spi_start !== 1'b0 || host_grant !== 1'b0 || host_done !== 1'b0 ||
        round_done !== 1'b0 || frame_active !== 1'b0 || spi_slave !== 3'd0 || timeout_err !== 1'b0) begin
      $display("FAIL reset_state: ss_n=%b start=%b grant=%b done=%b rd=%b act=%b slave=%0d to=%b expected all idle/zero",
               ss_n, spi_start, host_grant, host_done, round_done, frame_active, spi_slave, timeout_err);
      errors++;
    end
    @(negedge clock);
    reset = 1'b0;
    step();
    checks++;
    if (ss_n !== ALL1 || frame_active !== 1'b0) begin
      $display("FAIL idle_disabled: ss_n=%b active=%b expected %b 0", ss_n, frame_active, ALL1);
      errors++;
    end
  endtask

  task automatic test_round_robin();
    model_ptr  = NS - 1;
    slave_mask = 7'b0000101;
    enable     = 1'b1;
    rr_frame(10, -1, 1'b0, 1);
    repeat (3) rr_frame(10, -1, 1'b0, GAP);
  endtask

  task automatic test_host_insert();
    rr_frame(10, 6, 1'b0, GAP);
    host_frame(6, 12);
    rr_frame(10, -1, 1'b0, GAP);
  endtask

  task automatic test_random();
    int inj;
    for (int r = 0; r < 3; r++) begin
      slave_mask = NS'($urandom_range(1, (1 << NS) - 1));
      for (int f = 0; f < 5; f++) begin
        inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : -1;
        rr_frame($urandom_range(2, 25), inj, 1'b0, GAP);
        if (inj >= 0) host_frame(inj, $urandom_range(2, 25));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    slave_mask = 7'b0110100;
    n = 0;
    do begin step(); n++; end while (spi_start !== 1'b1 && n < 400);
    checks++;
    if (spi_start !== 1'b1) begin
      $display("FAIL reset_mid_wait: spi_start=%b expected 1", spi_start);
      errors++;
    end
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ss_n !== ALL1 || frame_active !== 1'b0 || spi_start !== 1'b0) begin
      $display("FAIL reset_mid_frame: ss_n=%b active=%b start=%b expected %b 0 0",
               ss_n, frame_active, spi_start, ALL1);
      errors++;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_ptr = NS - 1;
    rr_frame(8, -1, 1'b0, 1);
  endtask

  task automatic test_enable_drop();
    int bad;
    rr_frame(10, -1, 1'b1, GAP);
    bad = 0;
    repeat (GAP + 60) begin
      step();
      if (ss_n !== ALL1 || spi_start !== 1'b0 || frame_active !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL enable_drop: %0d active cycles after disable, expected 0", bad);
      errors++;
    end
  endtask

  task automatic test_host_invalid();
    int n, bad;
    host_req   = 1'b1;
    host_slave = 3'd7;
    n = 0;
    do begin step(); n++; end while (host_grant !== 1'b1 && n < 10);
    checks++;
    if (host_grant !== 1'b1 || host_done !== 1'b1) begin
      $display("FAIL host_invalid_pulse: grant=%b done=%b expected 1 1", host_grant, host_done);
      errors++;
    end
    checks++;
    if (ss_n !== ALL1) begin
      $display("FAIL host_invalid_ss: ss_n=%b expected %b", ss_n, ALL1);
      errors++;
    end
    host_req = 1'b0;
    bad = 0;
    repeat (60) begin
      step();
      if (ss_n !== ALL1 || spi_start !== 1'b0 || host_grant !== 1'b0 || frame_active !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL host_invalid_quiet: %0d active cycles expected 0", bad);
      errors++;
    end
  endtask

`ifdef MYO_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n, s1, s2;
    slave_mask = 7'b0000011;
    enable     = 1'b1;
    s1 = next_rr(model_ptr, slave_mask);
    s2 = next_rr(s1, slave_mask);
    n = 0;
    do begin step(); n++; end while (spi_start !== 1'b1 && n < 400);
    n = 0;
    do begin step(); n++; end while (ss_n !== ALL1 && n < 100);
    checks++;
    if (n != TMO) begin
      $display("FAIL timeout_len: got %0d cycles expected %0d", n, TMO);
      errors++;
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      $display("FAIL timeout_flag: got %b expected 1", timeout_err);
      errors++;
    end
    n = 0;
    do begin step(); n++; end while (ss_n === ALL1 && n < 400);
    checks++;
    if (ss_n !== ss_for(s2) || timeout_err !== 1'b1) begin
      $display("FAIL timeout_continue: ss_n=%b flag=%b expected %b 1", ss_n, timeout_err, ss_for(s2));
      errors++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_host_insert();
    test_random();
    test_reset_mid_frame();
    test_enable_drop();
    test_host_invalid();
`ifdef MYO_SCHED_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (timeout_err !== 1'b0) begin
      $display("FAIL timeout_tied: got %b expected 0", timeout_err);
      errors++;
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
